// File: rtl/sr_drv_pkg.sv
// Shared constants for the NAND-latch pulse driver: FSM encodings and counter width.
package sr_drv_pkg;
    localparam int CNT_W = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PULSE_S = 3'd1;
    localparam logic [2:0] ST_PULSE_R = 3'd2;
    localparam logic [2:0] ST_GUARD   = 3'd3;
    localparam logic [2:0] ST_CHECK   = 3'd4;
endpackage

// File: rtl/sr_latch_driver_if.sv
// Request/drive/readback bundle between a requester+latch and the driver.
interface sr_latch_driver_if;
    logic set_req;
    logic clr_req;
    logic ready;
    logic s_n;
    logic r_n;
    logic q;
    logic q_not;
    logic done;
    logic err;
    logic state_q;

    modport slave (
        input  set_req, clr_req, q, q_not,
        output ready, s_n, r_n, done, err, state_q
    );

    modport master (
        output set_req, clr_req, q, q_not,
        input  ready, s_n, r_n, done, err, state_q
    );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] ff_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff_q <= '0;
        else     ff_q <= {ff_q[0], d_i};
    end

    assign q_o = ff_q[1];
endmodule

// File: rtl/sr_latch_driver.sv
// Drives an external NAND SR latch with timed active-low pulses, then reads it
// back through synchronizers and confirms the requested value.
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int GUARD_CYCLES = 2
) (
    input logic              clk,
    input logic              rst,
    sr_latch_driver_if.slave bus
);
    localparam logic [CNT_W-1:0] P_LD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] G_LD = CNT_W'(GUARD_CYCLES - 1);

    logic [2:0]       st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             exp_q, exp_d;
    logic             val_q, val_d;
    logic             err_q, err_d;
    logic             s_n_q, r_n_q, ready_q;
    logic             q_s, qn_s;
    logic             accept, go_set, go_clr, conflict, match, chk_ok, chk_fail;

    sync2 u_sync_q  (.clk(clk), .rst(rst), .d_i(bus.q),     .q_o(q_s));
    sync2 u_sync_qn (.clk(clk), .rst(rst), .d_i(bus.q_not), .q_o(qn_s));

    // ready_q gates acceptance so the first post-reset cycle ignores requests
    assign accept   = (st_q == ST_IDLE) && ready_q;
    assign go_set   = accept &&  bus.set_req && !bus.clr_req;
    assign go_clr   = accept && !bus.set_req &&  bus.clr_req;
    assign conflict = accept &&  bus.set_req &&  bus.clr_req;
    assign match    = (q_s == exp_q) && (qn_s == !exp_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= ST_IDLE;
            cnt_q   <= '0;
            exp_q   <= 1'b0;
            val_q   <= 1'b0;
            err_q   <= 1'b0;
            s_n_q   <= 1'b1;
            r_n_q   <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            val_q   <= val_d;
            err_q   <= err_d;
            // drives decoded from the next state keep them registered and exclusive
            s_n_q   <= (st_d != ST_PULSE_S);
            r_n_q   <= (st_d != ST_PULSE_R);
            ready_q <= (st_d == ST_IDLE);
        end
    end

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        exp_d = exp_q;
        case (st_q)
            ST_IDLE: begin
                if (go_set) begin
                    st_d  = ST_PULSE_S;
                    cnt_d = P_LD;
                    exp_d = 1'b1;
                end else if (go_clr) begin
                    st_d  = ST_PULSE_R;
                    cnt_d = P_LD;
                    exp_d = 1'b0;
                end
            end
            ST_PULSE_S, ST_PULSE_R: begin
                if (cnt_q == '0) begin
                    st_d  = ST_GUARD;
                    cnt_d = G_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GUARD: begin
                if (cnt_q == '0) begin
                    st_d  = ST_CHECK;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CHECK: begin
                st_d  = ST_IDLE;
                cnt_d = '0;
            end
            default: begin
                st_d  = ST_IDLE;
                cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        chk_ok   = (st_q == ST_CHECK) &&  match;
        chk_fail = (st_q == ST_CHECK) && !match;
        err_d    = err_q | conflict | chk_fail;
        val_d    = chk_ok ? exp_q : val_q;
    end

    assign bus.ready   = ready_q;
    assign bus.s_n     = s_n_q;
    assign bus.r_n     = r_n_q;
    assign bus.done    = chk_ok;
    assign bus.err     = err_q | chk_fail;
    assign bus.state_q = val_q;
endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: behavioural NAND latch, timeline model, directed requests.
module tb_sr_latch_driver;
    localparam int P = 4;
    localparam int G = 2;

    logic clk = 1'b0;
    logic rst;
    logic stuck = 1'b0;
    logic lat_q = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    sr_latch_driver_if bus();

    sr_latch_driver #(.PULSE_CYCLES(P), .GUARD_CYCLES(G)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // NAND latch: low on s_n sets, low on r_n clears, otherwise holds
    always @(bus.s_n or bus.r_n or stuck) begin
        if (stuck)                    lat_q = 1'b0;
        else if (!bus.s_n && bus.r_n) lat_q = 1'b1;
        else if (!bus.r_n && bus.s_n) lat_q = 1'b0;
    end
    assign bus.q     = lat_q;
    assign bus.q_not = ~lat_q;

    task automatic chk(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
        end
    endtask

    // Timeline model: a request seen in cycle t0 drives low in t0+1..t0+P,
    // guards for G cycles, reports in t0+P+G+1 and frees the driver after that.
    int   m_t0 = 0;
    int   m_last_rst = 0;
    logic m_act = 1'b0, m_kind = 1'b0, m_sq = 1'b0, m_err = 1'b0;

    always @(negedge clk) begin
        int   c;
        logic busy, e_rdy, e_sn, e_rn, chkc, pass, e_done, e_err;
        c = cyc;
        busy = 1'b0; chkc = 1'b0; pass = 1'b0;
        if (rst) begin
            m_act = 1'b0; m_err = 1'b0; m_sq = 1'b0; m_last_rst = c;
            e_rdy = 1'b0; e_sn = 1'b1; e_rn = 1'b1; e_done = 1'b0; e_err = 1'b0;
        end else begin
            busy   = m_act && (c <= m_t0 + P + G + 1);
            e_rdy  = (c >= m_last_rst + 2) && !busy;
            e_sn   = !(busy &&  m_kind && c >= m_t0 + 1 && c <= m_t0 + P);
            e_rn   = !(busy && !m_kind && c >= m_t0 + 1 && c <= m_t0 + P);
            chkc   = busy && (c == m_t0 + P + G + 1);
            pass   = (lat_q == m_kind);
            e_done = chkc && pass;
            e_err  = m_err || (chkc && !pass);
        end
        chk("ready",   bus.ready,   e_rdy);
        chk("s_n",     bus.s_n,     e_sn);
        chk("r_n",     bus.r_n,     e_rn);
        chk("done",    bus.done,    e_done);
        chk("err",     bus.err,     e_err);
        chk("state_q", bus.state_q, m_sq);
        chk("no_overlap", !(!bus.s_n && !bus.r_n), 1'b1);
        if (!rst) begin
            if (chkc) begin
                if (pass) m_sq = m_kind;
                else      m_err = 1'b1;
                m_act = 1'b0;
            end
            if (e_rdy && bus.set_req && bus.clr_req) begin
                m_err = 1'b1;
            end else if (e_rdy && (bus.set_req ^ bus.clr_req)) begin
                m_act  = 1'b1;
                m_t0   = c;
                m_kind = bus.set_req;
            end
        end
    end

    task automatic at_cyc(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic req(input int k, input logic s, input logic r);
        at_cyc(k);
        bus.set_req = s;
        bus.clr_req = r;
        at_cyc(k + 1);
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
    endtask

    task automatic mid(input int k);
        at_cyc(k);
        @(negedge clk);
        #1;
    endtask

    initial begin
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
        rst = 1'b1;
        at_cyc(3);
        rst = 1'b0;
        mid(3);  chk("lit_ready_rel", bus.ready, 1'b0);
        mid(4);  chk("lit_ready_on", bus.ready, 1'b1);
                 chk("lit_sq_rst", bus.state_q, 1'b0);

        req(10, 1'b1, 1'b0);
        mid(11); chk("lit_set_sn11", bus.s_n, 1'b0);
        mid(14); chk("lit_set_sn14", bus.s_n, 1'b0);
        mid(15); chk("lit_set_sn15", bus.s_n, 1'b1);
        mid(17); chk("lit_set_done", bus.done, 1'b1);
        mid(18); chk("lit_set_sq", bus.state_q, 1'b1);

        req(20, 1'b0, 1'b1);
        mid(21); chk("lit_clr_rn21", bus.r_n, 1'b0);
        mid(27); chk("lit_clr_done", bus.done, 1'b1);
        mid(28); chk("lit_clr_sq", bus.state_q, 1'b0);

        at_cyc(29); stuck = 1'b1;
        req(30, 1'b1, 1'b0);
        mid(37); chk("lit_stuck_err", bus.err, 1'b1);
                 chk("lit_stuck_done", bus.done, 1'b0);
        mid(38); chk("lit_stuck_sq", bus.state_q, 1'b0);
        at_cyc(40); stuck = 1'b0;

        req(42, 1'b1, 1'b1);
        mid(43); chk("lit_both_ready", bus.ready, 1'b1);
                 chk("lit_both_sn", bus.s_n, 1'b1);
        req(44, 1'b1, 1'b0);
        req(47, 1'b0, 1'b1);
        mid(51); chk("lit_after_err_done", bus.done, 1'b1);
        mid(52); chk("lit_after_err_sq", bus.state_q, 1'b1);

        req(55, 1'b0, 1'b1);
        at_cyc(57);
        rst = 1'b1;
        #1;
        chk("lit_async_rn", bus.r_n, 1'b1);
        chk("lit_async_sn", bus.s_n, 1'b1);
        at_cyc(59);
        rst = 1'b0;
        mid(60); chk("lit_rst_ready", bus.ready, 1'b1);
                 chk("lit_rst_err", bus.err, 1'b0);
        mid(63); chk("lit_rst_done", bus.done, 1'b0);

        req(65, 1'b1, 1'b0);
        mid(72); chk("lit_final_done", bus.done, 1'b1);
        at_cyc(80);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sr_latch_driver.md
SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

Interface
REQ-001 Parameter PULSE_CYCLES, default 4, sets the active-low pulse width in clk cycles; legal range 1..15.
REQ-002 Parameter GUARD_CYCLES, default 2, sets the idle time (both outputs high) after each pulse before readback; legal range 2..15.
REQ-003 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 set_req  input  1  single-cycle request to drive the latch to q=1.
REQ-006 clr_req  input  1  single-cycle request to drive the latch to q=0.
REQ-007 ready  output  1  high when a request can be accepted.
REQ-008 s_n  output  1  active-low set drive to the external NAND latch.
REQ-009 r_n  output  1  active-low reset drive to the external NAND latch.
REQ-010 q  input  1  latch true output, asynchronous to clk.
REQ-011 q_not  input  1  latch complement output, asynchronous to clk.
REQ-012 done  output  1  one-cycle pulse when readback matches the requested value.
REQ-013 err  output  1  sticky error flag.
REQ-014 state_q  output  1  last confirmed latch value.

Function
REQ-015 FSM states: IDLE, PULSE_S, PULSE_R, GUARD, CHECK.
REQ-016 IDLE: ready=1, s_n=1, r_n=1; all other states: ready=0.
REQ-017 IDLE, set_req=1 and clr_req=0: go to PULSE_S; the expected value is 1.
REQ-018 IDLE, clr_req=1 and set_req=0: go to PULSE_R; the expected value is 0.
REQ-019 IDLE, set_req=1 and clr_req=1 in the same cycle: the request is rejected, no pulse is issued, err is set, and the FSM stays in IDLE.
REQ-020 Requests that arrive while ready=0 are ignored silently and do not set err.
REQ-021 PULSE_S drives s_n=0 and r_n=1; PULSE_R drives r_n=0 and s_n=1; each pulse lasts exactly PULSE_CYCLES cycles, then the FSM goes to GUARD.
REQ-022 s_n and r_n are never low in the same cycle, under any input sequence.
REQ-023 s_n and r_n are registered outputs; there is no combinational path from any input to them.
REQ-024 GUARD drives s_n=1 and r_n=1 for exactly GUARD_CYCLES cycles, then the FSM goes to CHECK.
REQ-025 q and q_not each pass through a 2-flop synchronizer before any use.
REQ-026 CHECK lasts one cycle. If the synchronized q equals the expected value and the synchronized q_not equals its complement: done=1 and state_q takes the expected value. Otherwise err=1 and state_q is unchanged. CHECK always returns to IDLE.
REQ-027 Latency: request accepted at edge N -> first low drive cycle N+1 -> done/err at cycle N+1+PULSE_CYCLES+GUARD_CYCLES.
REQ-028 A request at the same value as state_q still runs the full sequence.
REQ-029 err stays set until rst; it does not block later requests.
REQ-030 The cycle counter is 4 bits wide, loads on each state entry, counts down, and never wraps.

Reset
REQ-031 While rst=1: FSM=IDLE, s_n=1, r_n=1, ready=0, done=0, err=0, state_q=0, counter=0, synchronizer flops=0.
REQ-032 An rst asserted mid-pulse releases s_n/r_n high immediately (asynchronously); the request in flight is dropped and no done or err is produced.
REQ-033 ready goes high on the first clk edge after rst deasserts.

Structure
REQ-034 A shared header sr_drv_pkg holds the FSM state encodings (3-bit localparams) and the counter width constant.
REQ-035 The synchronizer is one sub-module, sync2 (1-bit, 2 flops), instantiated once for q and once for q_not.
REQ-036 The RTL also needs a behavioural NAND latch model as a bench-only module; it is not part of the deliverable.

Verification (PULSE_CYCLES=4, GUARD_CYCLES=2, NAND latch model attached)
REQ-037 rst for 3 cycles, then release -> s_n=r_n=1 throughout, ready=1 on the next edge, state_q=0, err=0.
REQ-038 set_req pulse at cycle 10 -> s_n=0 in cycles 11-14, both high in 15-16, done=1 at cycle 17, state_q=1, err=0.
REQ-039 clr_req following a set -> r_n=0 for 4 cycles, done after 7 cycles, state_q=0; at no cycle are s_n and r_n both low.
REQ-040 set_req=clr_req=1 in IDLE -> no pulse, err=1, ready stays 1; a later valid set_req still completes with done=1.
REQ-041 Latch model forced stuck at q=0 during a set -> err=1 at the CHECK cycle, done=0, state_q unchanged.
REQ-042 rst asserted during the 2nd pulse cycle -> s_n=1 within the same cycle, and neither done nor err is raised after release.
